// File: rtl/inst_trace_buf_pkg.sv
// Shared debug-trace definitions.
// Provides the packed trace entry {pc, instr, seq}, the capture FSM state
// encoding and the packed entry width used by the trace storage.
package inst_trace_buf_pkg;

  localparam int unsigned ENTRY_W = 96;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] seq;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_POST = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/inst_trace_buf_ram.sv
// Trace storage: DEPTH x ENTRY_W, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module inst_trace_buf_ram
  import inst_trace_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_trace_buf.sv
// Instruction trace buffer feeding the mnemonic decoder.
// Captures retired {pc, instr, seq} into a circular buffer while running,
// freezes POST captures after a trigger, then drains oldest-first.
// Ports: clk, resetn (async, active-low); cap_valid/cap_pc/cap_instr capture;
// trig, trig_pc_en/trig_pc trigger; clear; rd_valid/rd_ready/rd_pc/rd_instr/
// rd_seq read port; count, frozen, overflow status.
module inst_trace_buf
  import inst_trace_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned POST  = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cap_valid,
  input  logic [31:0]   cap_pc,
  input  logic [31:0]   cap_instr,
  input  logic          trig,
  input  logic          trig_pc_en,
  input  logic [31:0]   trig_pc,
  input  logic          clear,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_instr,
  output logic [31:0]   rd_seq,
  output logic [AW:0]   count,
  output logic          frozen,
  output logic          overflow
);

  state_t        state, state_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [AW-1:0] post_cnt, post_cnt_n;
  logic [AW:0]   cnt, cnt_n;
  logic [31:0]   seq, seq_n;
  logic          ovf, ovf_n;
  logic          we;
  logic          trig_ev;
  logic          full;
  logic          avail;
  trace_entry_t  wdata, rdata;

  inst_trace_buf_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_RUN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_cnt <= '0;
      cnt      <= '0;
      seq      <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      post_cnt <= post_cnt_n;
      cnt      <= cnt_n;
      seq      <= seq_n;
      ovf      <= ovf_n;
    end
  end

  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    post_cnt_n  = post_cnt;
    cnt_n       = cnt;
    seq_n       = seq;
    ovf_n       = ovf;
    we          = 1'b0;
    wdata.pc    = cap_pc;
    wdata.instr = cap_instr;
    wdata.seq   = seq;
    trig_ev     = trig | (trig_pc_en & cap_valid & (cap_pc == trig_pc));
    full        = (cnt == (AW+1)'(DEPTH));

    if (clear) begin
      // clear outranks trigger, capture and pop in the same cycle
      state_n    = ST_RUN;
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      post_cnt_n = '0;
      cnt_n      = '0;
      ovf_n      = 1'b0;
    end else begin
      case (state)
        ST_RUN, ST_POST: begin
          if (cap_valid) begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + AW'(1);
            seq_n    = seq + 32'd1;
            if (full) begin
              rd_ptr_n = rd_ptr + AW'(1);
              ovf_n    = 1'b1;
            end else begin
              cnt_n = cnt + (AW+1)'(1);
            end
          end
          if (state == ST_RUN) begin
            // a capture in the trigger cycle is pre-trigger; post_cnt is not touched
            if (trig_ev) begin
              if (POST == 0) begin
                state_n = ST_HOLD;
              end else begin
                state_n    = ST_POST;
                post_cnt_n = AW'(POST);
              end
            end
          end else if (cap_valid) begin
            post_cnt_n = post_cnt - AW'(1);
            if (post_cnt == AW'(1)) state_n = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (avail && rd_ready) begin
            rd_ptr_n = rd_ptr + AW'(1);
            cnt_n    = cnt - (AW+1)'(1);
          end
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

  assign avail    = (state == ST_HOLD) && (cnt != '0);
  assign rd_valid = avail;
  assign rd_pc    = avail ? rdata.pc    : '0;
  assign rd_instr = avail ? rdata.instr : '0;
  assign rd_seq   = avail ? rdata.seq   : '0;
  assign count    = cnt;
  assign frozen   = (state == ST_HOLD);
  assign overflow = ovf;

endmodule

// File: tb/tb_inst_trace_buf.sv
module tb_inst_trace_buf;
  import inst_trace_buf_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cap_valid = 1'b0;
  logic [31:0] cap_pc = '0;
  logic [31:0] cap_instr = '0;
  logic        trig = 1'b0;
  logic        trig_pc_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        clear = 1'b0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_pc, rd_instr, rd_seq;
  logic [4:0]  count;
  logic        frozen, overflow;

  int n_checks = 0;
  int n_fail = 0;
  trace_entry_t exp_q[$];
  trace_entry_t mon_e;

  inst_trace_buf #(
    .DEPTH(16),
    .AW   (4),
    .POST (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cap_valid (cap_valid),
    .cap_pc    (cap_pc),
    .cap_instr (cap_instr),
    .trig      (trig),
    .trig_pc_en(trig_pc_en),
    .trig_pc   (trig_pc),
    .clear     (clear),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_pc     (rd_pc),
    .rd_instr  (rd_instr),
    .rd_seq    (rd_seq),
    .count     (count),
    .frozen    (frozen),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] sq);
    trace_entry_t e;
    e.pc = pc;
    e.instr = instr;
    e.seq = sq;
    exp_q.push_back(e);
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cycle(input logic cv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic tg, input logic clr, input logic rr);
    cap_valid = cv; cap_pc = pc; cap_instr = instr;
    trig = tg; clear = clr; rd_ready = rr;
    @(posedge clk); #1;
    cap_valid = 1'b0; cap_pc = '0; cap_instr = '0;
    trig = 1'b0; clear = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic cap(input logic [31:0] pc, input logic [31:0] instr);
    cycle(1'b1, pc, instr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cap_valid = 1'b0; trig = 1'b0; clear = 1'b0; rd_ready = 1'b0; trig_pc_en = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
  endtask

  task automatic drain(input string nm);
    int unsigned k = 0;
    while (rd_valid && k < 40) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      k++;
    end
    chk({nm, "_rd_valid_low"}, rd_valid, 1'b0);
    chk({nm, "_all_popped"}, exp_q.size(), 0);
    chk({nm, "_rd_instr_nop"}, rd_instr, 32'h0);
  endtask

  // Scoreboard monitor: an entry is consumed when valid & ready meet at the edge.
  always @(negedge clk) begin
    if (resetn && rd_valid && rd_ready && !clear) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got seq %h, required no entry", rd_seq);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", rd_pc, mon_e.pc);
        chk("pop_instr", rd_instr, mon_e.instr);
        chk("pop_seq", rd_seq, mon_e.seq);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk("reset_count", count, 0);
    chk("reset_frozen", frozen, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_pc", rd_pc, 0);
    chk("reset_rd_seq", rd_seq, 0);

    // Fill below depth, trigger, four post captures, drain.
    for (int i = 0; i < 5; i++) begin
      cap(32'h100 + 32'(4 * i), 32'h24080001 + 32'(i));
      push_exp(32'h100 + 32'(4 * i), 32'h24080001 + 32'(i), 32'(i));
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("t1_post_not_frozen", frozen, 0);
    chk("t1_post_rd_valid", rd_valid, 0);
    chk("t1_count5", count, 5);
    for (int i = 5; i < 9; i++) begin
      cap(32'h100 + 32'(4 * i), 32'h24080001 + 32'(i));
      push_exp(32'h100 + 32'(4 * i), 32'h24080001 + 32'(i), 32'(i));
    end
    chk("t1_frozen", frozen, 1);
    chk("t1_count9", count, 9);
    chk("t1_first_pc", rd_pc, 32'h100);
    drain("t1");
    chk("t1_hold_after_empty", frozen, 1);
    chk("t1_count0", count, 0);

    // Wrap and overflow.
    do_reset();
    for (int i = 0; i < 20; i++) cap(32'h2000 + 32'(4 * i), 32'h1000 + 32'(i));
    chk("t2_overflow_run", overflow, 1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 20; i < 24; i++) cap(32'h2000 + 32'(4 * i), 32'h1000 + 32'(i));
    for (int i = 8; i < 24; i++) push_exp(32'h2000 + 32'(4 * i), 32'h1000 + 32'(i), 32'(i));
    chk("t2_count16", count, 16);
    chk("t2_overflow", overflow, 1);
    chk("t2_first_seq", rd_seq, 8);
    drain("t2");
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("t2_clear_overflow", overflow, 0);
    chk("t2_clear_run", frozen, 0);

    // PC-match trigger on the 7th capture.
    do_reset();
    trig_pc_en = 1'b1;
    trig_pc = 32'hBFC00380;
    for (int i = 0; i < 14; i++) begin
      cap(32'hBFC00368 + 32'(4 * i), 32'h3C000000 + 32'(i));
      if (i < 11) push_exp(32'hBFC00368 + 32'(4 * i), 32'h3C000000 + 32'(i), 32'(i));
    end
    chk("t3_frozen", frozen, 1);
    chk("t3_count11", count, 11);
    drain("t3");
    trig_pc_en = 1'b0;
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    // capture with trigger is pre-trigger; seq resumes at 11 after clear
    cycle(1'b1, 32'h3000, 32'h3100, 1'b1, 1'b0, 1'b0);
    push_exp(32'h3000, 32'h3100, 32'd11);
    for (int k = 1; k < 5; k++) begin
      cap(32'h3000 + 32'(4 * k), 32'h3100 + 32'(k));
      push_exp(32'h3000 + 32'(4 * k), 32'h3100 + 32'(k), 32'd11 + 32'(k));
      if (k == 3) chk("t3_not_frozen_after3", frozen, 0);
    end
    chk("t3b_frozen", frozen, 1);
    chk("t3b_count5", count, 5);
    drain("t3b");

    // Clear together with trigger and capture; clear in HOLD with rd_ready.
    do_reset();
    cap(32'h4000, 32'h4100);
    cap(32'h4004, 32'h4101);
    cycle(1'b1, 32'h4008, 32'h4102, 1'b1, 1'b1, 1'b0);
    chk("t4_count0", count, 0);
    chk("t4_frozen", frozen, 0);
    for (int i = 0; i < 5; i++) cap(32'h4100 + 32'(4 * i), 32'h4200 + 32'(i));
    chk("t4_run_count5", count, 5);
    chk("t4_still_run", frozen, 0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cap(32'h4200 + 32'(4 * i), 32'h4300 + 32'(i));
    chk("t4_frozen9", count, 9);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    chk("t4_clear_hold_count", count, 0);
    chk("t4_clear_hold_run", frozen, 0);

    // Read handshake with gaps.
    do_reset();
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cap(32'h5000 + 32'(4 * i), 32'h5100 + 32'(i));
      push_exp(32'h5000 + 32'(4 * i), 32'h5100 + 32'(i), 32'(i));
    end
    chk("t5_count4", count, 4);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("t5_count3", count, 3);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("t5_pop1", count, 2);
    chk("t5_seq_before_gap", rd_seq, 2);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("t5_gap_count", count, 2);
    chk("t5_gap_seq", rd_seq, 2);
    chk("t5_gap_pc", rd_pc, 32'h5008);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("t5_pop3", count, 1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("t5_pop4", count, 0);
    chk("t5_rd_valid", rd_valid, 0);
    chk("t5_rd_instr", rd_instr, 0);
    chk("t5_queue", exp_q.size(), 0);

    // Async reset mid-drain.
    do_reset();
    cap(32'h6000, 32'h6100);
    cap(32'h6004, 32'h6101);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 2; i < 6; i++) cap(32'h6000 + 32'(4 * i), 32'h6100 + 32'(i));
    chk("t6_count6", count, 6);
    chk("t6_valid", rd_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_rd_valid", rd_valid, 0);
    chk("t6_async_rd_pc", rd_pc, 0);
    chk("t6_async_rd_instr", rd_instr, 0);
    chk("t6_async_rd_seq", rd_seq, 0);
    chk("t6_async_count", count, 0);
    chk("t6_async_frozen", frozen, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    chk("t6_run", frozen, 0);
    cycle(1'b1, 32'h7000, 32'h7100, 1'b1, 1'b0, 1'b0);
    push_exp(32'h7000, 32'h7100, 32'd0);
    for (int i = 1; i < 5; i++) begin
      cap(32'h7000 + 32'(4 * i), 32'h7100 + 32'(i));
      push_exp(32'h7000 + 32'(4 * i), 32'h7100 + 32'(i), 32'(i));
    end
    chk("t6_frozen", frozen, 1);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
